// File: rtl/spu_decoder_pkg.sv
// Shared opcode tables, internal even-pipe codes and the decode bundle type.
// DECODER_HALFWORD_OPS_EN enables the ah/ahi halfword entries in the lookup helpers.
package spu_decoder_pkg;

    localparam int ADDR_W = 7;
    localparam int INST_W = 32;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 10;

    localparam logic [10:0] OP11_A   = 11'h0C0;
    localparam logic [10:0] OP11_AH  = 11'h0C8;
    localparam logic [10:0] OP11_SF  = 11'h040;
    localparam logic [10:0] OP11_AND = 11'h0C1;
    localparam logic [10:0] OP11_OR  = 11'h041;
    localparam logic [10:0] OP11_XOR = 11'h241;
    localparam logic [10:0] OP11_NOR = 11'h049;

    localparam logic [7:0] OP8_AI   = 8'h1C;
    localparam logic [7:0] OP8_AHI  = 8'h1D;
    localparam logic [7:0] OP8_SFI  = 8'h0C;
    localparam logic [7:0] OP8_ANDI = 8'h14;
    localparam logic [7:0] OP8_ORI  = 8'h04;
    localparam logic [7:0] OP8_XORI = 8'h44;

    localparam logic [OP_W-1:0] EOP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] EOP_A    = 6'd1;
    localparam logic [OP_W-1:0] EOP_AH   = 6'd2;
    localparam logic [OP_W-1:0] EOP_SF   = 6'd3;
    localparam logic [OP_W-1:0] EOP_AND  = 6'd4;
    localparam logic [OP_W-1:0] EOP_OR   = 6'd5;
    localparam logic [OP_W-1:0] EOP_XOR  = 6'd6;
    localparam logic [OP_W-1:0] EOP_NOR  = 6'd7;
    localparam logic [OP_W-1:0] EOP_AI   = 6'd8;
    localparam logic [OP_W-1:0] EOP_AHI  = 6'd9;
    localparam logic [OP_W-1:0] EOP_SFI  = 6'd10;
    localparam logic [OP_W-1:0] EOP_ANDI = 6'd11;
    localparam logic [OP_W-1:0] EOP_ORI  = 6'd12;
    localparam logic [OP_W-1:0] EOP_XORI = 6'd13;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rd;
        logic [IMM_W-1:0]  imm;
        logic              imm_sel;
    } even_bundle_t;

    // EOP_NOP doubles as "no match", since every real even code is non-zero.
    function automatic logic [OP_W-1:0] rr_code(input logic [10:0] op11);
        logic [OP_W-1:0] code;
        case (op11)
            OP11_A:   code = EOP_A;
`ifdef DECODER_HALFWORD_OPS_EN
            OP11_AH:  code = EOP_AH;
`endif
            OP11_SF:  code = EOP_SF;
            OP11_AND: code = EOP_AND;
            OP11_OR:  code = EOP_OR;
            OP11_XOR: code = EOP_XOR;
            OP11_NOR: code = EOP_NOR;
            default:  code = EOP_NOP;
        endcase
        return code;
    endfunction

    function automatic logic [OP_W-1:0] ri10_code(input logic [7:0] op8);
        logic [OP_W-1:0] code;
        case (op8)
            OP8_AI:   code = EOP_AI;
`ifdef DECODER_HALFWORD_OPS_EN
            OP8_AHI:  code = EOP_AHI;
`endif
            OP8_SFI:  code = EOP_SFI;
            OP8_ANDI: code = EOP_ANDI;
            OP8_ORI:  code = EOP_ORI;
            OP8_XORI: code = EOP_XORI;
            default:  code = EOP_NOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/spu_even_inst_decode.sv
// Combinational classifier: one instruction word -> even-pipe flag and decode bundle.
// Halfword ops follow DECODER_HALFWORD_OPS_EN through the package lookup helpers.
module spu_even_inst_decode
    import spu_decoder_pkg::*;
(
    input  logic [INST_W-1:0] inst_i,
    output logic              is_even_o,
    output even_bundle_t      bundle_o
);

    logic [OP_W-1:0] ri_code_s;
    logic [OP_W-1:0] rr_code_s;

    assign ri_code_s = ri10_code(inst_i[31:24]);
    assign rr_code_s = rr_code(inst_i[31:21]);

    // RI10 wins over RR when both lookups hit
    always_comb begin
        is_even_o = 1'b0;
        bundle_o  = '0;
        if (ri_code_s != EOP_NOP) begin
            is_even_o        = 1'b1;
            bundle_o.op      = ri_code_s;
            bundle_o.ra      = inst_i[13:7];
            bundle_o.rb      = 7'd0;
            bundle_o.rd      = inst_i[6:0];
            bundle_o.imm     = inst_i[23:14];
            bundle_o.imm_sel = 1'b1;
        end else if (rr_code_s != EOP_NOP) begin
            is_even_o        = 1'b1;
            bundle_o.op      = rr_code_s;
            bundle_o.ra      = inst_i[13:7];
            bundle_o.rb      = inst_i[20:14];
            bundle_o.rd      = inst_i[6:0];
            bundle_o.imm     = 10'd0;
            bundle_o.imm_sel = 1'b0;
        end else begin
            is_even_o = 1'b0;
            bundle_o  = '0;
        end
    end

endmodule

// File: rtl/spu_even_decoder.sv
// Dual-issue even-pipe front-end decoder; serialises even/even pairs over two cycles.
// Optional halfword ops (ah/ahi) are enabled by DECODER_HALFWORD_OPS_EN.
module spu_even_decoder
    import spu_decoder_pkg::*;
#(
    parameter int addrWidth = 7,
    parameter int instWidth = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stallIn,
    input  logic [2*instWidth-1:0] instIn,
    output logic                   stallOut,
    output logic [instWidth-1:0]   inst0,
    output logic [instWidth-1:0]   inst1,
    output logic [instWidth-1:0]   tempInst,
    output logic [5:0]             opOutEven,
    output logic [addrWidth-1:0]   raEven,
    output logic [addrWidth-1:0]   rbEven,
    output logic [addrWidth-1:0]   rdEven,
    output logic [9:0]             immeNumEven,
    output logic                   immeSelEven
);

    logic [instWidth-1:0] inst0_q, inst0_d;
    logic [instWidth-1:0] inst1_q, inst1_d;
    logic [instWidth-1:0] temp_q, temp_d;
    logic                 stall_q, stall_d;
    even_bundle_t         bundle_q, bundle_d;

    logic [instWidth-1:0] slot0_s;
    logic [instWidth-1:0] slot1_s;
    logic                 even0_s, even1_s;
    even_bundle_t         dec0_s, dec1_s;

    assign slot0_s = instIn[2*instWidth-1:instWidth];
    // While a pair is pending, the slot1 decoder looks at the deferred word instead.
    assign slot1_s = stall_q ? temp_q : instIn[instWidth-1:0];

    spu_even_inst_decode u_dec_slot0 (
        .inst_i    (slot0_s),
        .is_even_o (even0_s),
        .bundle_o  (dec0_s)
    );

    spu_even_inst_decode u_dec_slot1 (
        .inst_i    (slot1_s),
        .is_even_o (even1_s),
        .bundle_o  (dec1_s)
    );

    // Next-state selection: downstream stall, pending second word, or fresh pair
    always_comb begin
        inst0_d  = inst0_q;
        inst1_d  = inst1_q;
        temp_d   = temp_q;
        stall_d  = stall_q;
        bundle_d = bundle_q;
        if (stallIn) begin
            bundle_d = bundle_q;
        end else if (stall_q) begin
            bundle_d = dec1_s;
            stall_d  = 1'b0;
        end else begin
            inst0_d = slot0_s;
            inst1_d = instIn[instWidth-1:0];
            if (even0_s && even1_s) begin
                bundle_d = dec0_s;
                temp_d   = instIn[instWidth-1:0];
                stall_d  = 1'b1;
            end else if (even0_s) begin
                bundle_d = dec0_s;
            end else if (even1_s) begin
                bundle_d = dec1_s;
            end else begin
                bundle_d = '0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            inst0_q  <= '0;
            inst1_q  <= '0;
            temp_q   <= '0;
            stall_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            inst0_q  <= inst0_d;
            inst1_q  <= inst1_d;
            temp_q   <= temp_d;
            stall_q  <= stall_d;
            bundle_q <= bundle_d;
        end
    end

    assign stallOut    = stall_q;
    assign inst0       = inst0_q;
    assign inst1       = inst1_q;
    assign tempInst    = temp_q;
    assign opOutEven   = bundle_q.op;
    assign raEven      = bundle_q.ra;
    assign rbEven      = bundle_q.rb;
    assign rdEven      = bundle_q.rd;
    assign immeNumEven = bundle_q.imm;
    assign immeSelEven = bundle_q.imm_sel;

endmodule

// File: tb/tb_spu_even_decoder.sv
// Self-checking bench: directed scenarios plus random pairs against a table-driven model.
module tb_spu_even_decoder;

`ifdef DECODER_HALFWORD_OPS_EN
    localparam bit HW_EN = 1'b1;
`else
    localparam bit HW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stallIn;
    logic [63:0] instIn;
    logic        stallOut;
    logic [31:0] inst0, inst1, tempInst;
    logic [5:0]  opOutEven;
    logic [6:0]  raEven, rbEven, rdEven;
    logic [9:0]  immeNumEven;
    logic        immeSelEven;

    int vectors = 0;
    int miscompares = 0;

    spu_even_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .stallIn     (stallIn),
        .instIn      (instIn),
        .stallOut    (stallOut),
        .inst0       (inst0),
        .inst1       (inst1),
        .tempInst    (tempInst),
        .opOutEven   (opOutEven),
        .raEven      (raEven),
        .rbEven      (rbEven),
        .rdEven      (rdEven),
        .immeNumEven (immeNumEven),
        .immeSelEven (immeSelEven)
    );

    always #4 clk = ~clk;

    logic [10:0] rr_ops   [0:6] = '{11'h0C0, 11'h0C8, 11'h040, 11'h0C1, 11'h041, 11'h241, 11'h049};
    logic [5:0]  rr_codes [0:6] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7};
    logic [7:0]  ri_ops   [0:5] = '{8'h1C, 8'h1D, 8'h0C, 8'h14, 8'h04, 8'h44};
    logic [5:0]  ri_codes [0:5] = '{6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13};

    // Reference model state: {op, ra, rb, rd, imm, sel} bundle plus pipeline registers
    logic        e_stall;
    logic [31:0] e_inst0, e_inst1, e_temp;
    logic [37:0] e_b;
    logic        last_adv;

    function automatic logic [37:0] ref_bundle(input logic [31:0] w);
        for (int i = 0; i < 6; i++)
            if (w[31:24] == ri_ops[i] && (HW_EN || ri_codes[i] != 6'd9))
                return {ri_codes[i], w[13:7], 7'd0, w[6:0], w[23:14], 1'b1};
        for (int i = 0; i < 7; i++)
            if (w[31:21] == rr_ops[i] && (HW_EN || rr_codes[i] != 6'd2))
                return {rr_codes[i], w[13:7], w[20:14], w[6:0], 10'd0, 1'b0};
        return 38'd0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 15);
        if (k < 7) w[31:21] = rr_ops[k];
        else if (k < 13) w[31:24] = ri_ops[k-7];
        return w;
    endfunction

    function automatic logic [134:0] obs_vec();
        return {stallOut, inst0, inst1, tempInst, opOutEven, raEven, rbEven, rdEven,
                immeNumEven, immeSelEven};
    endfunction

    function automatic logic [134:0] exp_vec();
        return {e_stall, e_inst0, e_inst1, e_temp, e_b};
    endfunction

    task automatic model_edge();
        logic [37:0] b0, b1;
        if (reset) begin
            e_stall = 1'b0; e_inst0 = '0; e_inst1 = '0; e_temp = '0; e_b = '0;
        end else if (stallIn) begin
            e_b = e_b;
        end else if (e_stall) begin
            e_b = ref_bundle(e_temp);
            e_stall = 1'b0;
        end else begin
            e_inst0 = instIn[63:32];
            e_inst1 = instIn[31:0];
            b0 = ref_bundle(instIn[63:32]);
            b1 = ref_bundle(instIn[31:0]);
            if (b0[37:32] != 6'd0 && b1[37:32] != 6'd0) begin
                e_b = b0; e_temp = instIn[31:0]; e_stall = 1'b1;
            end else if (b0[37:32] != 6'd0) begin
                e_b = b0;
            end else begin
                e_b = b1;
            end
        end
    endtask

    task automatic step();
        last_adv = !reset && !stallIn && !e_stall;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stallIn = 1'b0; instIn = 64'h1C00_0001_0C10_0002;
        e_stall = 1'b1; e_inst0 = '1; e_inst1 = '1; e_temp = '1; e_b = '1;
        step();
        vectors++;
        if (obs_vec() !== 135'd0) begin
            $display("FAIL reset_state: got %h want 0", obs_vec()); miscompares++;
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec()); miscompares++;
        end
        #5 reset = 1'b0;
    endtask

    task automatic test_ori();
        instIn = 64'h04111111_10222222;
        step();
        vectors++;
        if ({opOutEven, raEven, rbEven, rdEven, immeNumEven, immeSelEven, stallOut, inst0, inst1}
            !== {6'd12, 7'h22, 7'h00, 7'h11, 10'h044, 1'b1, 1'b0, 32'h04111111, 32'h10222222}) begin
            $display("FAIL ori_slot0: got %h", obs_vec()); miscompares++;
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL ori_model: got %h want %h", obs_vec(), exp_vec()); miscompares++;
        end
    endtask

    task automatic test_both_even();
        instIn = 64'h08111111_18222222;
        step();
        vectors++;
        if ({opOutEven, raEven, rbEven, rdEven, immeSelEven, stallOut, tempInst}
            !== {6'd3, 7'h22, 7'h44, 7'h11, 1'b0, 1'b1, 32'h18222222}) begin
            $display("FAIL pair_edge1: got %h", obs_vec()); miscompares++;
        end
        step();
        vectors++;
        if ({opOutEven, raEven, rbEven, rdEven, immeSelEven, stallOut}
            !== {6'd4, 7'h44, 7'h08, 7'h22, 1'b0, 1'b0}) begin
            $display("FAIL pair_edge2: got %h", obs_vec()); miscompares++;
        end
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL pair_model: got %h want %h", obs_vec(), exp_vec()); miscompares++;
        end
    endtask

    task automatic test_stall_pending();
        instIn = 64'h08111111_18222222;
        step();
        stallIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({opOutEven, raEven, rbEven, rdEven, stallOut, tempInst}
                !== {6'd3, 7'h22, 7'h44, 7'h11, 1'b1, 32'h18222222}) begin
                $display("FAIL stall_hold: got %h", obs_vec()); miscompares++;
            end
        end
        stallIn = 1'b0;
        step();
        vectors++;
        if ({opOutEven, raEven, rbEven, rdEven, stallOut} !== {6'd4, 7'h44, 7'h08, 7'h22, 1'b0}) begin
            $display("FAIL stall_release: got %h", obs_vec()); miscompares++;
        end
    endtask

    task automatic test_nop();
        instIn = 64'h10222222_10222222;
        step();
        vectors++;
        if ({opOutEven, raEven, rbEven, rdEven, immeNumEven, immeSelEven, stallOut} !== 45'd0) begin
            $display("FAIL nop_pair: got %h want bundle 0", obs_vec()); miscompares++;
        end
    endtask

    task automatic test_reset_mid_stall();
        instIn = 64'h08111111_18222222;
        step();
        reset = 1'b1;
        step();
        vectors++;
        if (obs_vec() !== 135'd0) begin
            $display("FAIL reset_mid_stall: got %h want 0", obs_vec()); miscompares++;
        end
        reset = 1'b0;
        instIn = 64'h10222222_10222222;
        step();
        vectors++;
        if ({opOutEven, stallOut} !== 7'd0) begin
            $display("FAIL pending_dropped: op=%0d stall=%0d want 0 0", opOutEven, stallOut);
            miscompares++;
        end
    endtask

    task automatic test_halfword();
        instIn = {11'h0C8, 21'h0ABCDE, 8'h1D, 24'h123456};
        step();
        vectors++;
        if ({stallOut, opOutEven} !== {HW_EN, HW_EN ? 6'd2 : 6'd0}) begin
            $display("FAIL halfword: stall=%0d op=%0d want %0d %0d", stallOut, opOutEven,
                     HW_EN, HW_EN ? 2 : 0);
            miscompares++;
        end
        step();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL halfword_model: got %h want %h", obs_vec(), exp_vec()); miscompares++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if (last_adv) instIn = {rand_word(), rand_word()};
            stallIn = ($urandom_range(0, 4) == 0);
            reset   = ($urandom_range(0, 59) == 0);
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
                miscompares++;
            end
        end
        reset = 1'b0;
        stallIn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ori();
        test_both_even();
        test_stall_pending();
        test_nop();
        test_reset_mid_stall();
        test_halfword();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
